read_port_arbiter: RTL and testbench
====================================

# read_port_arbiter

Shares the single instruction/data memory read port between the fetch stage (instruction requester) and the load unit (data requester). Accepts one request per cycle and forwards it to memory. Records the source of each outstanding request in an in-order tag queue, then routes each in-order memory response back to its requester. Supports a fetch flush that silently discards responses to instruction requests issued before a branch misprediction.

## Interface
Parameters:
- TAG_DEPTH, 4: maximum outstanding memory requests. Power of two, ≥2.
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request waits. Range 1–15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_addr  in  32  instruction request address
- i_avalid  in  1  instruction request present
- i_aready  out  1  instruction request accepted this cycle
- i_flush  in  1  fetch redirect (pred_miss); discards pending instruction responses
- i_valid  out  1  instruction response valid
- i_data  out  32  instruction response data
- d_addr  in  32  data request address
- d_avalid  in  1  data request present
- d_aready  out  1  data request accepted this cycle
- d_valid  out  1  data response valid
- d_data  out  32  data response data
- m_addr  out  32  memory request address
- m_avalid  out  1  memory request valid
- m_aready  in  1  memory accepts request
- m_valid  in  1  memory response valid, strictly in request order
- m_data  in  32  memory response data
- err  out  1  sticky: m_valid seen with tag queue empty

## Operation
- **Arbitration (combinational):**
  - Candidate exists when (i_avalid | d_avalid) and the tag queue is not full.
  - Data wins by default.
  - Instruction wins when d_avalid is low, or when starve_cnt == STARVE_LIMIT and i_avalid is high.
  - m_avalid = candidate exists. m_addr = winner's address.
  - m_addr = 0 when there is no candidate.
- **Accept:**
  - Acceptance occurs when m_avalid & m_aready.
  - Only the winner's aready is asserted, and only in the accepting cycle.
  - The requester must hold avalid/addr stable until its aready is seen.
- **Tag queue:**
  - Circular FIFO of TAG_DEPTH entries {src (0=inst, 1=data), discard}.
  - Push on accept with discard=0.
  - Pop on m_valid.
  - Full is evaluated before the same-cycle pop: a full queue blocks a push even if it pops that cycle.
  - Pointers wrap modulo TAG_DEPTH. Count width is clog2(TAG_DEPTH)+1.
- **Response routing (combinational, same cycle as m_valid):**
  - Head entry src=0, discard=0: i_valid=1, i_data=m_data.
  - Head entry src=1: d_valid=1, d_data=m_data.
  - Head entry with discard=1: popped with no valid output.
  - Non-selected data output is 0.
- **Flush:**
  - i_flush sets discard on every queued entry with src=0, taking effect at the clock edge.
  - A response to an instruction entry arriving in the flush cycle is also suppressed: i_valid=0.
  - An instruction request accepted in the flush cycle is the redirected fetch. It is pushed with discard=0 and is not discarded.
  - Data entries are unaffected.
- **Starvation counter starve_cnt (registered):**
  - Increments, saturating at STARVE_LIMIT, when i_avalid & data accepted.
  - Clears when an instruction request is accepted or i_avalid=0.
  - Otherwise holds.
- **Error:**
  - m_valid with the queue empty: no pop, no valid output, err set.
  - err is cleared only by rst.

## Timing
- **Reset:**
  - Queue empty, starve_cnt=0, err=0.
  - While rst=1: m_avalid=0, i_aready=0, d_aready=0, i_valid=0, d_valid=0, all data/address outputs 0.
  - rst asserted mid-operation abandons all outstanding tags. Responses arriving after reset are flagged as err.
- **Latency:**
  - Request path: 0 cycles (requester avalid to m_avalid, combinational).
  - Response path: 0 cycles (m_valid to i_valid/d_valid).
  - Arbiter adds no pipeline stage. The memory defines round-trip latency.
- **Throughput:** one accept and one response per cycle, concurrently.
- **Simultaneous events:**
  - Accept + response in the same cycle: count unchanged, when the queue is not full.
  - Flush + accept + response in the same cycle: the old head is dropped and the new entry pushed clean.

## Test plan
- **Back-to-back instruction requests:** 1-cycle memory latency, addrs 0x0, 0x4, 0x8. Required: three i_valid pulses with matching data in order, i_aready every cycle, no data-port activity.
- **Mixed traffic:** both requesters continuously valid, STARVE_LIMIT=4. Required: grant pattern D,D,D,D,I repeating. starve_cnt returns to 0 after each I grant.
- **Full queue:** TAG_DEPTH=4, memory never responds. Required: exactly 4 accepts, then m_avalid=0. A response on the cycle the queue is full frees a slot only on the following cycle.
- **Flush discard:** two instruction requests outstanding (0x100, 0x104), then i_flush with a new request to 0x200 in the same cycle. Required: responses for 0x100 and 0x104 produce no i_valid. The 0x200 response produces i_valid.
- **Interleaved flush:** queue holding I, D, I entries, then flush. Required: only the D response surfaces (d_valid with correct data). Both I responses are dropped.
- **Reset and protocol errors:** rst asserted with 3 outstanding. Required: all outputs 0 during rst, queue empty after release. A late m_valid sets err, which stays set until the next rst.

Source files
------------

// File: rtl/read_port_arbiter_if.sv
// Request/response bundle between the fetch stage, load unit, shared memory read port
// and the read port arbiter.
interface read_port_arbiter_if;
    localparam int unsigned DW = 32;

    logic [DW-1:0] i_addr;
    logic          i_avalid;
    logic          i_aready;
    logic          i_flush;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic [DW-1:0] d_addr;
    logic          d_avalid;
    logic          d_aready;
    logic          d_valid;
    logic [DW-1:0] d_data;
    logic [DW-1:0] m_addr;
    logic          m_avalid;
    logic          m_aready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          err;

    // Arbiter side
    modport slave (
        input  i_addr, i_avalid, i_flush, d_addr, d_avalid, m_aready, m_valid, m_data,
        output i_aready, i_valid, i_data, d_aready, d_valid, d_data, m_addr, m_avalid, err
    );

    // Requester/memory environment side
    modport master (
        output i_addr, i_avalid, i_flush, d_addr, d_avalid, m_aready, m_valid, m_data,
        input  i_aready, i_valid, i_data, d_aready, d_valid, d_data, m_addr, m_avalid, err
    );
endinterface

// File: rtl/read_port_arbiter.sv
// Shares one memory read port between instruction fetch and load unit, tracking the
// source of each outstanding request in an in-order tag queue for response routing.
module read_port_arbiter #(
    parameter int unsigned TAG_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    read_port_arbiter_if.slave   bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = 4;

    logic [TAG_DEPTH-1:0] q_src;
    logic [TAG_DEPTH-1:0] q_disc;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [SW-1:0]        starve_cnt;
    logic                 err_q;

    logic full;
    logic empty;
    logic cand;
    logic inst_win;
    logic accept;
    logic pop;
    logic head_src;
    logic head_disc;

    // Arbitration and acceptance; full is judged before any same-cycle pop
    always_comb begin
        full     = (count == CW'(TAG_DEPTH));
        empty    = (count == '0);
        cand     = !rst && (bus.i_avalid || bus.d_avalid) && !full;
        inst_win = !bus.d_avalid || ((starve_cnt == SW'(STARVE_LIMIT)) && bus.i_avalid);
        accept   = cand && bus.m_aready;
        pop      = !rst && bus.m_valid && !empty;
        head_src  = q_src[rd_ptr];
        head_disc = q_disc[rd_ptr];
    end

    assign bus.m_avalid = cand;
    assign bus.m_addr   = cand ? (inst_win ? bus.i_addr : bus.d_addr) : '0;
    assign bus.i_aready = accept && inst_win;
    assign bus.d_aready = accept && !inst_win;

    // Response routing; an instruction head in a flush cycle is already stale
    assign bus.i_valid = pop && !head_src && !head_disc && !bus.i_flush;
    assign bus.d_valid = pop && head_src;
    assign bus.i_data  = bus.i_valid ? bus.m_data : '0;
    assign bus.d_data  = bus.d_valid ? bus.m_data : '0;
    assign bus.err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_src      <= '0;
            q_disc     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            // Flush marks queued instruction tags; the push below lands clean
            for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
                if (bus.i_flush && !q_src[k]) q_disc[k] <= 1'b1;
            end
            if (accept) begin
                q_src[wr_ptr]  <= !inst_win;
                q_disc[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(accept) - CW'(pop);

            if (!bus.i_avalid || bus.i_aready)
                starve_cnt <= '0;
            else if (bus.d_aready && (starve_cnt != SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + SW'(1);

            if (bus.m_valid && empty) err_q <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, DW[0]};
endmodule

// File: tb/tb_read_port_arbiter.sv
// Directed self-checking bench for read_port_arbiter (TAG_DEPTH=4, STARVE_LIMIT=4).
module tb_read_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail    = 0;

    read_port_arbiter_if bus ();

    read_port_arbiter #(.TAG_DEPTH(4), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_addr   = '0;
        bus.i_avalid = 1'b0;
        bus.i_flush  = 1'b0;
        bus.d_addr   = '0;
        bus.d_avalid = 1'b0;
        bus.m_aready = 1'b1;
        bus.m_valid  = 1'b0;
        bus.m_data   = '0;
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit later
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic resp(input logic [31:0] data);
        bus.m_valid = 1'b1;
        bus.m_data  = data;
    endtask

    logic prev_i;
    logic exp_i;

    initial begin
        idle();
        // Reset: outputs forced low even with requests and a response present
        rst = 1'b1;
        bus.i_avalid = 1'b1; bus.i_addr = 32'h44; resp(32'hDEAD);
        cyc();
        chk("rst_m_avalid", 32'(bus.m_avalid), 0);
        chk("rst_m_addr",   bus.m_addr, 0);
        chk("rst_i_aready", 32'(bus.i_aready), 0);
        chk("rst_i_valid",  32'(bus.i_valid), 0);
        chk("rst_i_data",   bus.i_data, 0);
        chk("rst_err",      32'(bus.err), 0);
        idle(); rst = 1'b0;
        cyc();
        chk("post_rst_m_avalid", 32'(bus.m_avalid), 0);

        // Back-to-back instruction fetches with 1-cycle memory latency
        bus.i_avalid = 1'b1; bus.i_addr = 32'h0;
        #1;
        chk("b2b_m_addr0", bus.m_addr, 32'h0);
        chk("b2b_i_aready0", 32'(bus.i_aready), 1);
        chk("b2b_d_aready0", 32'(bus.d_aready), 0);
        cyc();
        bus.i_addr = 32'h4; resp(32'hA000_0000); #1;
        chk("b2b_m_addr4", bus.m_addr, 32'h4);
        chk("b2b_i_aready4", 32'(bus.i_aready), 1);
        chk("b2b_i_valid0", 32'(bus.i_valid), 1);
        chk("b2b_i_data0", bus.i_data, 32'hA000_0000);
        chk("b2b_d_valid0", 32'(bus.d_valid), 0);
        cyc();
        bus.i_addr = 32'h8; resp(32'hA000_0004); #1;
        chk("b2b_i_aready8", 32'(bus.i_aready), 1);
        chk("b2b_i_data4", bus.i_data, 32'hA000_0004);
        cyc();
        bus.i_avalid = 1'b0; resp(32'hA000_0008); #1;
        chk("b2b_i_valid8", 32'(bus.i_valid), 1);
        chk("b2b_i_data8", bus.i_data, 32'hA000_0008);
        chk("b2b_d_data", bus.d_data, 0);
        chk("b2b_idle_m_avalid", 32'(bus.m_avalid), 0);
        cyc(); idle(); #1;

        // Mixed traffic: grants D,D,D,D,I repeating; each grant answered next cycle
        bus.i_avalid = 1'b1; bus.i_addr = 32'h1000;
        bus.d_avalid = 1'b1; bus.d_addr = 32'h2000;
        prev_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_i = ((k % 5) == 4);
            bus.m_valid = (k > 0);
            bus.m_data  = 32'h5000 + 32'(k);
            #1;
            chk($sformatf("mix_m_addr%0d", k), bus.m_addr, exp_i ? 32'h1000 : 32'h2000);
            chk($sformatf("mix_i_aready%0d", k), 32'(bus.i_aready), 32'(exp_i));
            chk($sformatf("mix_d_aready%0d", k), 32'(bus.d_aready), 32'(!exp_i));
            if (k > 0) begin
                chk($sformatf("mix_i_valid%0d", k), 32'(bus.i_valid), 32'(prev_i));
                chk($sformatf("mix_d_valid%0d", k), 32'(bus.d_valid), 32'(!prev_i));
            end
            prev_i = exp_i;
            cyc();
        end
        idle(); resp(32'h5999); #1;
        chk("mix_last_i_valid", 32'(bus.i_valid), 1);
        chk("mix_last_i_data", bus.i_data, 32'h5999);
        cyc(); idle(); #1;

        // Full queue: four accepts, then blocked; a response frees a slot a cycle later
        bus.d_avalid = 1'b1; bus.d_addr = 32'h3000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("full_d_aready%0d", k), 32'(bus.d_aready), 1);
            cyc();
        end
        chk("full_m_avalid", 32'(bus.m_avalid), 0);
        chk("full_d_aready", 32'(bus.d_aready), 0);
        resp(32'h77); #1;
        chk("full_pop_m_avalid", 32'(bus.m_avalid), 0);
        chk("full_pop_d_valid", 32'(bus.d_valid), 1);
        chk("full_pop_d_data", bus.d_data, 32'h77);
        cyc();
        bus.m_valid = 1'b0; #1;
        chk("full_freed_m_avalid", 32'(bus.m_avalid), 1);
        chk("full_freed_d_aready", 32'(bus.d_aready), 1);
        cyc();
        bus.d_avalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            resp(32'h80 + 32'(k)); #1;
            chk($sformatf("drain_d_valid%0d", k), 32'(bus.d_valid), 1);
            cyc();
        end
        idle(); #1;

        // Flush discard: 0x100, 0x104 outstanding, flush with redirect to 0x200
        bus.i_avalid = 1'b1; bus.i_addr = 32'h100; cyc();
        bus.i_addr = 32'h104; cyc();
        bus.i_addr = 32'h200; bus.i_flush = 1'b1; #1;
        chk("fl_redirect_aready", 32'(bus.i_aready), 1);
        chk("fl_redirect_addr", bus.m_addr, 32'h200);
        cyc();
        idle(); resp(32'h1100); #1;
        chk("fl_drop100", 32'(bus.i_valid), 0);
        cyc();
        resp(32'h1104); #1;
        chk("fl_drop104", 32'(bus.i_valid), 0);
        cyc();
        resp(32'h1200); #1;
        chk("fl_keep200_valid", 32'(bus.i_valid), 1);
        chk("fl_keep200_data", bus.i_data, 32'h1200);
        cyc(); idle(); #1;

        // Interleaved flush: queue I,D,I; flush + accept + head response together
        bus.i_avalid = 1'b1; bus.i_addr = 32'h400; cyc();
        bus.i_avalid = 1'b0; bus.d_avalid = 1'b1; bus.d_addr = 32'h500; cyc();
        bus.d_avalid = 1'b0; bus.i_avalid = 1'b1; bus.i_addr = 32'h404; cyc();
        bus.i_addr = 32'h600; bus.i_flush = 1'b1; resp(32'h2400); #1;
        chk("ifl_head_i_valid", 32'(bus.i_valid), 0);
        chk("ifl_new_aready", 32'(bus.i_aready), 1);
        cyc();
        idle(); resp(32'h2500); #1;
        chk("ifl_d_valid", 32'(bus.d_valid), 1);
        chk("ifl_d_data", bus.d_data, 32'h2500);
        cyc();
        resp(32'h2404); #1;
        chk("ifl_drop404_i", 32'(bus.i_valid), 0);
        chk("ifl_drop404_d", 32'(bus.d_valid), 0);
        cyc();
        resp(32'h2600); #1;
        chk("ifl_keep600", 32'(bus.i_valid), 1);
        chk("ifl_err_clear", 32'(bus.err), 0);
        cyc(); idle(); #1;

        // Reset with three outstanding, then a late response raises sticky err
        bus.d_avalid = 1'b1; bus.d_addr = 32'h700;
        cyc(); cyc(); cyc();
        rst = 1'b1; resp(32'hBEEF); bus.i_avalid = 1'b1; #1;
        chk("mrst_m_avalid", 32'(bus.m_avalid), 0);
        chk("mrst_d_aready", 32'(bus.d_aready), 0);
        chk("mrst_d_valid", 32'(bus.d_valid), 0);
        chk("mrst_d_data", bus.d_data, 0);
        chk("mrst_m_addr", bus.m_addr, 0);
        cyc();
        rst = 1'b0; idle(); #1;
        chk("mrst_rel_err", 32'(bus.err), 0);
        cyc();
        resp(32'hCAFE); #1;
        chk("late_d_valid", 32'(bus.d_valid), 0);
        chk("late_i_valid", 32'(bus.i_valid), 0);
        cyc();
        idle(); #1;
        chk("late_err_set", 32'(bus.err), 1);
        cyc();
        chk("late_err_sticky", 32'(bus.err), 1);
        rst = 1'b1; cyc();
        rst = 1'b0; #1;
        chk("err_cleared_by_rst", 32'(bus.err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
